dsc_par_clkdiv_mul: RTL and testbench

Deterministic stochastic-computing (DSC) multiplier for NUM_INPUTS unsigned DATA_WIDTH-bit fractions. It uses clock-division unary streams and evaluates PAR bit positions per clock. It generalises the fixed by-4, two-input ordered multiplier to any input count and any power-of-two parallelism, and adds a busy/done handshake. It sits behind the same `core` harness in the arch-sweep flow and presents exact product counts on `bin_data_out`.

---
 rtl/dsc_par_clkdiv_mul.sv | 163 ++++++++++++++++
 tb/tb_dsc_par_clkdiv_mul.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsc_par_clkdiv_mul.sv
// Deterministic stochastic-computing multiplier over clock-division unary streams, PAR positions per clock.
// Optional macro DSC_EARLY_TERM_EN: zero-operand fast exit and skipping of guaranteed-zero blocks.
module dsc_par_clkdiv_mul #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int PAR        = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  bin_data_in,
  output logic [DATA_WIDTH*NUM_INPUTS:0]         bin_data_out,
  output logic                                   busy,
  output logic                                   done
);

  localparam int NK = DATA_WIDTH * NUM_INPUTS;
  localparam int IW = DATA_WIDTH + 1;
  localparam logic [NK:0]   PAR_STEP = (NK+1)'(PAR);
  localparam logic [IW-1:0] PAR_INC  = IW'(PAR);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                                state_r;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] ops_r;
  logic [NK-1:0]                         t_r;
  logic [NK:0]                           acc_r;

  logic                  upper_ok_s;
  logic [DATA_WIDTH-1:0] base_s;
  logic [IW-1:0]         diff_s;
  logic [IW-1:0]         inc_s;
  logic [NK:0]           step_s;
  logic [NK:0]           next_t_s;
  logic [NK:0]           acc_next_s;
  logic                  last_s;

`ifdef DSC_EARLY_TERM_EN
  logic zero_r;

  // Distance from t to the start of the next block of operand k (block length 2^(N*k)).
  function automatic logic [NK:0] blk_rem(input logic [NK-1:0] t, input int k);
    logic [NK:0] blk;
    blk = {{NK{1'b0}}, 1'b1} << (DATA_WIDTH * k);
    return blk - ({1'b0, t} & (blk - {{NK{1'b0}}, 1'b1}));
  endfunction

  function automatic logic any_zero(input logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] ops);
    logic z;
    z = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      z = z | (ops[k] == '0);
    end
    return z;
  endfunction
`endif

  // Ones contributed by the current window and the position of the next window.
  always_comb begin
    upper_ok_s = 1'b1;
    for (int k = 1; k < NUM_INPUTS; k++) begin
      upper_ok_s = upper_ok_s & (t_r[DATA_WIDTH*k +: DATA_WIDTH] < ops_r[k]);
    end
    base_s = t_r[DATA_WIDTH-1:0];
    diff_s = {1'b0, ops_r[0]} - {1'b0, base_s};
    if (!upper_ok_s || (ops_r[0] <= base_s)) begin
      inc_s = '0;
    end else if (diff_s > PAR_INC) begin
      inc_s = PAR_INC;
    end else begin
      inc_s = diff_s;
    end
    step_s = PAR_STEP;
`ifdef DSC_EARLY_TERM_EN
    // A higher operand whose bit is 0 stays 0 until its digit changes; jump there.
    for (int k = 1; k < NUM_INPUTS; k++) begin
      if ((t_r[DATA_WIDTH*k +: DATA_WIDTH] >= ops_r[k]) && (blk_rem(t_r, k) > step_s)) begin
        step_s = blk_rem(t_r, k);
      end else begin
        step_s = step_s;
      end
    end
`endif
    next_t_s   = {1'b0, t_r} + step_s;
    last_s     = next_t_s[NK];
    acc_next_s = acc_r + (NK+1)'(inc_s);
  end

  // Control FSM, accumulator, position counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      ops_r        <= '0;
      t_r          <= '0;
      acc_r        <= '0;
      bin_data_out <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef DSC_EARLY_TERM_EN
      zero_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (en) begin
            ops_r <= bin_data_in;
            acc_r <= '0;
            t_r   <= '0;
            busy  <= 1'b1;
`ifdef DSC_EARLY_TERM_EN
            zero_r  <= any_zero(bin_data_in);
            state_r <= any_zero(bin_data_in) ? ST_DONE : ST_RUN;
`else
            state_r <= ST_RUN;
`endif
          end else begin
            busy <= 1'b0;
          end
        end
        ST_RUN: begin
          acc_r <= acc_next_s;
          t_r   <= next_t_s[NK-1:0];
          if (last_s) begin
            bin_data_out <= acc_next_s;
            done         <= 1'b1;
            state_r      <= ST_DONE;
          end else begin
            done <= 1'b0;
          end
        end
        ST_DONE: begin
`ifdef DSC_EARLY_TERM_EN
          // Zero-operand exit: the pulse is raised one edge after acceptance.
          if (zero_r) begin
            zero_r       <= 1'b0;
            bin_data_out <= '0;
            done         <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
`else
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
`endif
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsc_par_clkdiv_mul.sv
// Randomized bench for dsc_par_clkdiv_mul over four configurations, checked against a product/latency model.
module tb_dsc_par_clkdiv_mul;

  localparam int NC = 4;
  localparam int CN [NC] = '{5, 3, 3, 5};
  localparam int CK [NC] = '{2, 3, 3, 2};
  localparam int CP [NC] = '{4, 1, 2, 32};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tmo = 1'b0;
  logic        en_v   [NC];
  int          a_v    [NC][3];
  logic [63:0] out_v  [NC];
  logic        busy_v [NC];
  logic        done_v [NC];

  bit     mbusy [NC];
  bit     mdone [NC];
  longint mout  [NC];
  longint mprod [NC];
  int     mcnt  [NC];
  int     mlat  [NC];
  longint lit_out [NC];
  int     lit_lat [NC];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    localparam int N = CN[g];
    localparam int K = CK[g];
    localparam int P = CP[g];
    logic [K-1:0][N-1:0] din;
    logic [N*K:0]        dout;
    logic                b;
    logic                d;
    always_comb begin
      for (int k = 0; k < K; k++) din[k] = a_v[g][k][N-1:0];
    end
    dsc_par_clkdiv_mul #(.DATA_WIDTH(N), .NUM_INPUTS(K), .PAR(P)) u_dut (
      .clk(clk), .rst(rst), .en(en_v[g]), .bin_data_in(din),
      .bin_data_out(dout), .busy(b), .done(d)
    );
    assign out_v[g]  = 64'(dout);
    assign busy_v[g] = b;
    assign done_v[g] = d;
  end

  function automatic longint full_lat(input int g);
    return (longint'(1) << (CN[g] * CK[g])) / CP[g];
  endfunction

  function automatic longint product(input int g);
    longint p = 1;
    for (int k = 0; k < CK[g]; k++) p = p * a_v[g][k];
    return p;
  endfunction

  // Expected run length; -1 means data-dependent (only bounded by L).
  function automatic int model_lat(input int g, input longint p);
`ifdef DSC_EARLY_TERM_EN
    return (p == 0) ? 1 : -1;
`else
    return int'(full_lat(g)) + 0 * int'(p);
`endif
  endfunction

  function automatic int pick_lat(input int plain, input int early);
`ifdef DSC_EARLY_TERM_EN
    return early + 0 * plain;
`else
    return plain + 0 * early;
`endif
  endfunction

  function automatic int rnd(input int n);
    int m = (1 << n) - 1;
    case ($urandom_range(5, 0))
      0: return 0;
      1: return m;
      default: return int'($urandom_range(m, 0));
    endcase
  endfunction

  task automatic chk(input string nm, input int g, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[%0d] @%0t: got %0d, expected %0d", nm, g, $time, act, exp);
    end
  endtask

  // Model: a run is accepted when idle and en is high; result appears after the run length.
  always @(posedge clk or negedge rst) begin
    for (int g = 0; g < NC; g++) begin
      if (!rst) begin
        mbusy[g] = 1'b0; mdone[g] = 1'b0; mout[g] = 0; mcnt[g] = 0; mlat[g] = 0;
      end else if (!mbusy[g]) begin
        if (en_v[g]) begin
          mbusy[g] = 1'b1; mcnt[g] = 0;
          mprod[g] = product(g);
          mlat[g]  = model_lat(g, mprod[g]);
        end
      end else begin
        mcnt[g]++;
        if (mlat[g] < 0) begin
          if (done_v[g] || (mcnt[g] > full_lat(g) + 2)) begin
            mbusy[g] = 1'b0; mout[g] = mprod[g];
          end
        end else if (mcnt[g] == mlat[g]) begin
          mout[g] = mprod[g]; mdone[g] = 1'b1;
        end else if (mcnt[g] == mlat[g] + 1) begin
          mbusy[g] = 1'b0; mdone[g] = 1'b0;
        end
      end
    end
  end

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    chk("timeout", 0, longint'(tmo), 0);
    for (int g = 0; g < NC; g++) begin
      if (mbusy[g] && (mlat[g] < 0)) begin
        chk("busy", g, longint'(busy_v[g]), 1);
        if (done_v[g]) begin
          chk("result", g, longint'(out_v[g]), mprod[g]);
          chk("lat_bound", g, longint'(mcnt[g] <= full_lat(g)), 1);
        end
      end else begin
        chk("busy", g, longint'(busy_v[g]), longint'(mbusy[g]));
        chk("done", g, longint'(done_v[g]), longint'(mdone[g]));
        chk("out", g, longint'(out_v[g]), mout[g]);
      end
      if ((lit_out[g] >= 0) && (mdone[g] || (mbusy[g] && (mlat[g] < 0) && done_v[g]))) begin
        chk("lit_prod", g, mprod[g], lit_out[g]);
        if (lit_lat[g] > 0) chk("lit_lat", g, longint'(mcnt[g]), longint'(lit_lat[g]));
      end
    end
  end

  task automatic wait_idle(input int g);
    for (int i = 0; i < 2000; i++) begin
      if (!mbusy[g]) return;
      @(negedge clk);
    end
    tmo = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 tmo = 1'b0;
  endtask

  // Called on a falling edge; leaves on a falling edge with the instance idle.
  task automatic run(input int g, input int a0, input int a1, input int a2,
                     input longint lo, input int ll);
    wait_idle(g);
    a_v[g][0] = a0; a_v[g][1] = a1; a_v[g][2] = a2;
    lit_out[g] = lo; lit_lat[g] = ll;
    en_v[g] = 1'b1;
    @(posedge clk);
    #1 en_v[g] = 1'b0;
    @(negedge clk);
    wait_idle(g);
    lit_out[g] = -1; lit_lat[g] = 0;
  endtask

  initial begin
    for (int g = 0; g < NC; g++) begin
      en_v[g] = 1'b0; lit_out[g] = -1; lit_lat[g] = 0;
      for (int k = 0; k < 3; k++) a_v[g][k] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run(0, 31, 31, 0, 961, pick_lat(256, 249));
    run(0, 16, 8, 0, 128, pick_lat(256, 65));
    run(0, 1, 1, 0, 1, pick_lat(256, 9));
    run(0, 0, 17, 0, 0, pick_lat(256, 1));
    run(0, 31, 1, 0, 31, pick_lat(256, 9));

    // Abandon a run with an asynchronous reset, then start a fresh one.
    a_v[0][0] = 31; a_v[0][1] = 31; en_v[0] = 1'b1;
    @(posedge clk);
    #1 en_v[0] = 1'b0;
    repeat (100) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    run(0, 3, 5, 0, 15, pick_lat(256, 41));

    // en held high with operands churning during the run.
    a_v[0][0] = 7; a_v[0][1] = 9; lit_out[0] = 63; lit_lat[0] = pick_lat(256, 73);
    en_v[0] = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (mdone[0] || !mbusy[0]) break;
      a_v[0][0] = rnd(5); a_v[0][1] = rnd(5);
    end
    en_v[0] = 1'b0;
    wait_idle(0);
    lit_out[0] = -1; lit_lat[0] = 0;

    run(1, 7, 5, 3, 105, pick_lat(512, 0));
    run(2, 7, 5, 3, 105, pick_lat(256, 0));
    run(3, 13, 29, 0, 377, pick_lat(32, 0));

    for (int i = 0; i < 12; i++) run(0, rnd(5), rnd(5), 0, -1, 0);
    for (int i = 0; i < 30; i++) run(3, rnd(5), rnd(5), 0, -1, 0);
    for (int i = 0; i < 4; i++)  run(1, rnd(3), rnd(3), rnd(3), -1, 0);
    for (int i = 0; i < 4; i++)  run(2, rnd(3), rnd(3), rnd(3), -1, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
